// File: rtl/matrix_result_tx.sv
// -----------------------------------------------------------------------------
// matrix_result_tx
//
// Serialises the nine 18-bit results of a 3x3 matrix multiplier into a byte
// stream with a valid/ready handshake. A rising edge on `done` snapshots C and
// starts a frame:
//   [HEADER_BYTE]  (only when HEADER_EN = 1)
//   27 payload bytes: for each C[i], i = 0..8: C[i][7:0], C[i][15:8],
//                     {6'b0, C[i][17:16]}
//   1 checksum byte: XOR of the 27 payload bytes (header excluded)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   done        result-ready level from the multiplier (rising edge = start)
//   C[0:8]      multiplier results, row-major
//   clear       synchronous clear of the sticky overrun flag
//   data_ready  downstream can accept a byte
//   data_out    byte on offer
//   data_valid  data_out holds a valid byte
//   busy        a frame is in progress
//   frame_done  one-cycle pulse after the checksum byte is accepted
//   overrun     sticky: a done rising edge arrived while busy (not queued)
// -----------------------------------------------------------------------------
module matrix_result_tx #(
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [17:0] C [0:8],
  input  logic        clear,
  input  logic        data_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK
  } state_t;

  localparam logic [4:0] LAST_BYTE = 5'd26;

  state_t      state;
  state_t      state_nxt;
  logic        done_q;
  logic        start;
  logic        handshake;
  logic [4:0]  byte_idx;
  logic [17:0] snap    [0:8];
  logic [7:0]  payload [0:26];
  logic [7:0]  checksum;

  assign start      = done & ~done_q;
  assign busy       = (state != S_IDLE);
  // Every non-idle state has a byte on offer, so valid and busy coincide;
  // this also gives the one-cycle latency from done rising to the first byte.
  assign data_valid = busy;
  assign handshake  = data_valid & data_ready;

  // Flatten the snapshot into the payload byte order and fold the checksum.
  always_comb begin : payload_map
    checksum = '0;
    for (int i = 0; i < 9; i++) begin
      payload[3*i]   = snap[i][7:0];
      payload[3*i+1] = snap[i][15:8];
      payload[3*i+2] = {6'b0, snap[i][17:16]};
    end
    for (int k = 0; k < 27; k++) begin
      checksum = checksum ^ payload[k];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    // NOTE: assign a default before the case so no path leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)     state_nxt = HEADER_EN ? S_HEADER : S_DATA;
      S_HEADER: if (handshake) state_nxt = S_DATA;
      S_DATA:   if (handshake && (byte_idx == LAST_BYTE)) state_nxt = S_CHECK;
      S_CHECK:  if (handshake) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Output byte mux; idle drives zero so data_out is 0 during reset.
  always_comb begin : out_mux
    data_out = '0;
    case (state)
      S_HEADER: data_out = HEADER_BYTE;
      S_DATA:   data_out = payload[byte_idx];
      S_CHECK:  data_out = checksum;
      default:  data_out = '0;
    endcase
  end

  // Datapath: edge detect, snapshot, byte index, status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q     <= 1'b0;
      byte_idx   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      // NOTE: the snapshot is a small register bank, not RAM, and must read
      // as zero out of reset, so it is reset explicitly.
      for (int i = 0; i < 9; i++) begin
        snap[i] <= '0;
      end
    end else begin
      done_q     <= done;
      frame_done <= (state == S_CHECK) && handshake;

      // A new overrun event wins over a simultaneous clear.
      if (start && busy) begin
        overrun <= 1'b1;
      end else if (clear) begin
        overrun <= 1'b0;
      end

      if ((state == S_IDLE) && start) begin
        for (int i = 0; i < 9; i++) begin
          snap[i] <= C[i];
        end
        byte_idx <= '0;
      end else if ((state == S_DATA) && handshake) begin
        byte_idx <= (byte_idx == LAST_BYTE) ? 5'd0 : byte_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_tx
//
// Two instances: dut_h (header enabled) and dut_n (no header). Expected frames
// come from a byte-list model built from the C values captured when done rises.
// -----------------------------------------------------------------------------
module tb_matrix_result_tx;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [17:0] c [0:8];
  logic        done_h, ready_h, done_n, ready_n;
  logic [7:0]  dout_h, dout_n;
  logic        valid_h, valid_n, busy_h, busy_n, fd_h, fd_n, ovr_h, ovr_n;

  int checks = 0;
  int errors = 0;

  logic [17:0] model_c [0:8];
  bq_t         got;
  int          stable_err, busy_cycles, first_valid, fd_count;
  bit          timed_out;
  bit          clear_on_restart;

  always #5 clk = ~clk;

  matrix_result_tx #(.HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut_h (
    .clk(clk), .reset(reset), .done(done_h), .C(c), .clear(clear),
    .data_ready(ready_h), .data_out(dout_h), .data_valid(valid_h),
    .busy(busy_h), .frame_done(fd_h), .overrun(ovr_h)
  );

  matrix_result_tx #(.HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut_n (
    .clk(clk), .reset(reset), .done(done_n), .C(c), .clear(clear),
    .data_ready(ready_n), .data_out(dout_n), .data_valid(valid_n),
    .busy(busy_n), .frame_done(fd_n), .overrun(ovr_n)
  );

  // Reference frame: optional header, three little-endian bytes per element,
  // then the XOR of the payload bytes.
  function automatic bq_t expected_frame(input bit hdr);
    bq_t        q;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    if (hdr) q.push_back(8'hA5);
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'(model_c[i] >> (8 * k));
        q.push_back(b);
        x = x ^ b;
      end
    end
    q.push_back(x);
    return q;
  endfunction

  // Index of first difference between the captured and expected frames, -1 if equal.
  function automatic int first_diff(input bq_t e, output logic [7:0] gb, output logic [7:0] eb);
    int n;
    gb = 8'h00;
    eb = 8'h00;
    n = (got.size() < e.size()) ? got.size() : e.size();
    for (int i = 0; i < n; i++) begin
      if (got[i] !== e[i]) begin
        gb = got[i];
        eb = e[i];
        return i;
      end
    end
    if (got.size() != e.size()) return n;
    return -1;
  endfunction

  task automatic randomize_c();
    for (int i = 0; i < 9; i++) c[i] = 18'($urandom);
  endtask

  // Drop done for a cycle, capture C into the model, then raise done.
  task automatic start_frame(input bit sel);
    @(negedge clk);
    if (sel) done_n = 1'b0; else done_h = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) model_c[i] = c[i];
    if (sel) done_n = 1'b1; else done_h = 1'b1;
  endtask

  // Drive data_ready per mode (0 always, 1 toggling 1010.., 2 random) and
  // record accepted bytes until frame_done, stop_at accepted bytes, or budget.
  task automatic collect(input bit sel, input int mode, input int mutate_at,
                         input int restart_at, input int stop_at);
    bit         pv, prdy, v, b, fd, r, rs_pending;
    logic [7:0] pd, d;
    int         acc;
    got.delete();
    stable_err = 0; busy_cycles = 0; first_valid = -1; fd_count = 0;
    timed_out = 1'b1; acc = 0; pv = 1'b0; prdy = 1'b1; pd = 8'h00; rs_pending = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      clear = 1'b0;
      v  = sel ? valid_n : valid_h;
      d  = sel ? dout_n  : dout_h;
      b  = sel ? busy_n  : busy_h;
      fd = sel ? fd_n    : fd_h;
      if (fd) begin
        fd_count++;
        timed_out = 1'b0;
        break;
      end
      if (pv && !prdy && (!v || d !== pd)) stable_err++;
      if (b) busy_cycles++;
      if (v && first_valid < 0) first_valid = cyc;
      if (rs_pending) begin
        done_h = 1'b1;
        if (clear_on_restart) clear = 1'b1;
        rs_pending = 1'b0;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 2) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (sel) ready_n = r; else ready_h = r;
      if (v && r) begin
        got.push_back(d);
        acc++;
        if (acc == mutate_at) begin
          for (int i = 0; i < 9; i++) c[i] = 18'h3FFFF;
        end
        if (acc == restart_at) begin
          done_h = 1'b0;
          rs_pending = 1'b1;
        end
      end
      pv = v; pd = d; prdy = r;
      if (acc == stop_at) begin
        timed_out = 1'b0;
        break;
      end
    end
    clear = 1'b0;
  endtask

  task automatic watch_idle(input bit sel, input int n, output int activity);
    activity = 0;
    repeat (n) begin
      @(negedge clk);
      if (sel ? (valid_n | fd_n | busy_n) : (valid_h | fd_h | busy_h)) activity++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0;
    done_h = 1'b0; done_n = 1'b0; ready_h = 1'b0; ready_n = 1'b0;
    clear_on_restart = 1'b0;
    for (int i = 0; i < 9; i++) c[i] = 18'h3FFFF;
    #12;
    checks++;
    if ({dout_h, valid_h, busy_h, fd_h, ovr_h} !== 12'h000) begin
      errors++;
      $display("FAIL reset_h: out=%h valid=%b busy=%b fd=%b ovr=%b, all required 0",
               dout_h, valid_h, busy_h, fd_h, ovr_h);
    end
    checks++;
    if ({dout_n, valid_n, busy_n, fd_n, ovr_n} !== 12'h000) begin
      errors++;
      $display("FAIL reset_n: out=%h valid=%b busy=%b fd=%b ovr=%b, all required 0",
               dout_n, valid_n, busy_n, fd_n, ovr_n);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_h !== 1'b0 || busy_h !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", valid_h, busy_h);
    end
  endtask

  task automatic test_header_frame();
    bq_t        exp;
    int         d, act;
    logic [7:0] gb, eb;
    for (int i = 0; i < 9; i++) c[i] = 18'h0;
    c[0] = 18'h2ABCD;
    start_frame(1'b0);
    collect(1'b0, 0, -1, -1, -1);
    exp = expected_frame(1'b1);
    d = first_diff(exp, gb, eb);
    checks++;
    if (timed_out || d >= 0) begin
      errors++;
      $display("FAIL hdr_frame: timeout=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
               timed_out, got.size(), exp.size(), d, gb, eb);
    end
    checks++;
    if (got.size() != 29 || {got[0], got[1], got[2], got[3], got[28]} !== 40'hA5CDAB0264) begin
      errors++;
      $display("FAIL hdr_known_bytes: len=%0d, required 29 bytes A5 CD AB 02 .. 64", got.size());
    end
    checks++;
    if (first_valid != 0) begin
      errors++;
      $display("FAIL hdr_latency: first valid at sample %0d, required 0", first_valid);
    end
    checks++;
    if (busy_cycles != 29) begin
      errors++;
      $display("FAIL hdr_streaming: %0d busy cycles, required 29", busy_cycles);
    end
    watch_idle(1'b0, 3, act);
    checks++;
    if (fd_count != 1 || act != 0) begin
      errors++;
      $display("FAIL hdr_frame_done: pulses=%0d post-activity=%0d, required 1 and 0", fd_count, act);
    end
  endtask

  task automatic test_no_header_toggle();
    bq_t        exp;
    int         d;
    logic [7:0] gb, eb;
    for (int i = 0; i < 9; i++) c[i] = 18'(i + 1);
    start_frame(1'b1);
    collect(1'b1, 1, -1, -1, -1);
    exp = expected_frame(1'b0);
    d = first_diff(exp, gb, eb);
    checks++;
    if (timed_out || d >= 0) begin
      errors++;
      $display("FAIL nohdr_frame: timeout=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
               timed_out, got.size(), exp.size(), d, gb, eb);
    end
    checks++;
    if (got.size() != 28 || got[27] !== 8'h01 || got[0] !== 8'h01) begin
      errors++;
      $display("FAIL nohdr_checksum: len=%0d, required 28 bytes starting 01 ending 01", got.size());
    end
    checks++;
    if (stable_err != 0 || busy_cycles != 55) begin
      errors++;
      $display("FAIL nohdr_backpressure: unstable=%0d busy_cycles=%0d, required 0 and 55",
               stable_err, busy_cycles);
    end
    done_n = 1'b0;
  endtask

  task automatic test_snapshot();
    bq_t        exp;
    int         d;
    logic [7:0] gb, eb;
    randomize_c();
    start_frame(1'b0);
    collect(1'b0, 2, 5, -1, -1);
    exp = expected_frame(1'b1);
    d = first_diff(exp, gb, eb);
    checks++;
    if (timed_out || d >= 0 || stable_err != 0) begin
      errors++;
      $display("FAIL snapshot: timeout=%0d unstable=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
               timed_out, stable_err, got.size(), exp.size(), d, gb, eb);
    end
  endtask

  task automatic test_overrun();
    bq_t        exp;
    int         d, act;
    logic [7:0] gb, eb;
    randomize_c();
    clear_on_restart = 1'b0;
    start_frame(1'b0);
    checks++;
    if (ovr_h !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial: overrun=%b, required 0", ovr_h);
    end
    collect(1'b0, 0, -1, 10, -1);
    exp = expected_frame(1'b1);
    d = first_diff(exp, gb, eb);
    checks++;
    if (timed_out || d >= 0) begin
      errors++;
      $display("FAIL overrun_frame: timeout=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
               timed_out, got.size(), exp.size(), d, gb, eb);
    end
    checks++;
    if (ovr_h !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b, required 1", ovr_h);
    end
    watch_idle(1'b0, 20, act);
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL overrun_not_queued: %0d active cycles, required 0", act);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (ovr_h !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, required 0", ovr_h);
    end
    clear_on_restart = 1'b1;
    start_frame(1'b0);
    collect(1'b0, 2, -1, 7, -1);
    clear_on_restart = 1'b0;
    checks++;
    if (timed_out || ovr_h !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear_collision: timeout=%0d overrun=%b, required 0 and 1",
               timed_out, ovr_h);
    end
  endtask

  task automatic test_reset_midframe();
    bq_t        exp;
    int         d;
    logic [7:0] gb, eb;
    randomize_c();
    done_n = 1'b0;
    start_frame(1'b0);
    collect(1'b0, 0, -1, -1, 15);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (valid_h !== 1'b0 || busy_h !== 1'b0 || dout_h !== 8'h00 || ovr_h !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: valid=%b busy=%b out=%h ovr=%b, required 0 0 00 0",
               valid_h, busy_h, dout_h, ovr_h);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    collect(1'b0, 0, -1, -1, -1);
    exp = expected_frame(1'b1);
    d = first_diff(exp, gb, eb);
    checks++;
    if (timed_out || d >= 0 || first_valid != 0) begin
      errors++;
      $display("FAIL restart_after_reset: timeout=%0d first_valid=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
               timed_out, first_valid, got.size(), exp.size(), d, gb, eb);
    end
  endtask

  task automatic test_done_hold();
    int act;
    randomize_c();
    start_frame(1'b0);
    collect(1'b0, 0, -1, -1, -1);
    watch_idle(1'b0, 75, act);
    checks++;
    if (timed_out || fd_count != 1 || act != 0 || ovr_h !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: timeout=%0d pulses=%0d extra=%0d ovr=%b, required 0 1 0 0",
               timed_out, fd_count, act, ovr_h);
    end
  endtask

  task automatic test_random_frames();
    bq_t        exp;
    int         d;
    bit         sel;
    logic [7:0] gb, eb;
    for (int n = 0; n < 6; n++) begin
      sel = n[0];
      randomize_c();
      start_frame(sel);
      collect(sel, 2, (n > 2) ? int'($urandom_range(1, 20)) : -1, -1, -1);
      exp = expected_frame(!sel);
      d = first_diff(exp, gb, eb);
      checks++;
      if (timed_out || d >= 0 || stable_err != 0) begin
        errors++;
        $display("FAIL random_frame_%0d: timeout=%0d unstable=%0d len=%0d/%0d diff_idx=%0d got=%h exp=%h",
                 n, timed_out, stable_err, got.size(), exp.size(), d, gb, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_header_frame();
    test_no_header_toggle();
    test_snapshot();
    test_overrun();
    test_reset_midframe();
    test_done_hold();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/matrix_result_tx.md
MATRIX_RESULT_TX -- requirements
Module: matrix_result_tx

Interface
REQ-001 Parameter: HEADER_EN, default 1, 1 = emit header byte before payload, 0 = no header.
REQ-002 Parameter: HEADER_BYTE, default 8'hA5, value of the header byte.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 done  input  1  result-ready level from the 3x3 matrix multiplier; held high until the next multiply starts.
REQ-006 C  input  18 x [0:8]  unpacked array of multiplier results, row-major, C[0]..C[8].
REQ-007 clear  input  1  synchronous clear of the overrun flag.
REQ-008 data_ready  input  1  downstream ready to accept a byte.
REQ-009 data_out  output  8  transmitted byte.
REQ-010 data_valid  output  1  data_out holds a valid byte.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.
REQ-013 overrun  output  1  sticky flag; a done rising edge was seen while busy.

Function
REQ-014 The block SHALL register done into done_q every cycle and define start = done & ~done_q.
REQ-015 In IDLE, start SHALL snapshot all nine C values into internal registers, set busy, and move to HEADER if HEADER_EN = 1, otherwise to DATA.
REQ-016 data_valid SHALL be high in the cycle immediately after the edge at which start was sampled, giving 1-cycle latency from done rise to first byte.
REQ-017 States: IDLE, HEADER, DATA, CHECK. Transitions:
- HEADER->DATA on handshake.
- DATA->CHECK on the handshake of byte 26.
- CHECK->IDLE on handshake.
REQ-018 A handshake SHALL occur exactly when data_valid & data_ready at a rising edge; only then does the byte index advance.
REQ-019 While data_valid = 1 and data_ready = 0, data_out and data_valid SHALL hold stable.
REQ-020 data_ready SHALL be ignored when data_valid = 0.
REQ-021 Payload byte order SHALL be element i = 0..8, and for each element the three bytes C[i][7:0], C[i][15:8], {6'b0, C[i][17:16]}, giving 27 payload bytes.
REQ-022 CHECK SHALL send the XOR of all 27 payload bytes. The header is excluded from the checksum.
REQ-023 A frame is 28 bytes with HEADER_EN = 0 and 29 bytes with HEADER_EN = 1.
REQ-024 Transmitted values SHALL come from the snapshot only; changes on C during a frame SHALL NOT affect it.
REQ-025 On the CHECK handshake, the block SHALL:
- deassert busy and data_valid on the next cycle;
- pulse frame_done high for exactly that one cycle.
REQ-026 A start while busy = 1 SHALL NOT disturb the frame in progress and SHALL set overrun. This includes a start in the same cycle as the CHECK handshake.
REQ-027 A start while busy = 1 SHALL NOT be queued.
REQ-028 clear = 1 SHALL reset overrun to 0. If clear and a new overrun event coincide, overrun SHALL be 1.
REQ-029 done held high continuously SHALL produce only one frame; a new frame requires done to go low and then high again.
REQ-030 With data_ready held high, the frame SHALL stream one byte per cycle with no idle cycles between bytes.

Reset
REQ-031 While reset = 0, the following SHALL all be 0: data_out, data_valid, busy, frame_done, overrun, done_q, byte index and snapshot registers; state SHALL be IDLE.
REQ-032 Assertion of reset mid-frame SHALL abort the frame immediately (asynchronously) with no further bytes sent.
REQ-033 If done = 1 when reset is released, the first rising clock edge SHALL be treated as a start.

Verification
REQ-034 HEADER_EN = 1, C[0] = 18'h2ABCD, C[1..8] = 0, data_ready = 1, done rises -> bytes A5, CD, AB, 02, then 24 x 00, then 64 on consecutive cycles; frame_done pulses once.
REQ-035 HEADER_EN = 0, C[i] = i+1, data_ready toggling 1010... -> 28 bytes 01,00,00,02,00,00,...,09,00,00, then checksum 01; each byte held stable while data_ready = 0.
REQ-036 Mid-frame, C is changed to all 18'h3FFFF -> the remaining bytes still match the original snapshot.
REQ-037 done falls and rises again at byte 10 -> current frame completes unchanged, overrun = 1, no second frame; clear = 1 -> overrun = 0.
REQ-038 reset pulsed low at byte 15 -> data_valid and busy go 0 immediately; after release with done = 1, a new frame starts on the first edge.
REQ-039 done held high for 100 cycles -> exactly one frame, frame_done pulses once, overrun stays 0.
